alu_wb_stage: RTL
=================

ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 The block SHALL use one clock, `clk`, and a synchronous, active-high reset, `rst`; all state changes occur on the rising edge of `clk` only.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 in_valid  in  1  instruction present on in_op/in_dst/in_src0/in_src1/in_imm.
REQ-005 in_ready  out  1  block can accept; a transfer occurs on a cycle with in_valid & in_ready.
REQ-006 in_op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 LDI, 110 MUL, 111 NOP.
REQ-007 in_dst / in_src0 / in_src1  in  2 each  destination and source register indices.
REQ-008 in_imm  in  9  immediate value used by LDI.
REQ-009 rd0_addr / rd1_addr  out  2 each  register-file read addresses.
REQ-010 rd0_data / rd1_data  in  9 each  combinational register-file read data.
REQ-011 wr_en / wr_addr / wr_data  out  1/2/9  register-file write port.
REQ-012 busy  out  1  high while the multiplier FSM is not in RUN.
REQ-013 retire_cnt  out  16  count of register writes issued.

Function
REQ-014 rd0_addr SHALL equal in_src0 and rd1_addr SHALL equal in_src1 combinationally, every cycle.
REQ-015 Operand selection for src0, with the same rule applied independently to src1:
- if wr_en=1 and wr_addr=in_src0, the operand is wr_data (bypass);
- otherwise the operand is rd0_data.
REQ-016 All arithmetic SHALL be 9-bit unsigned, modulo 512.
- SUB is a - b mod 512.
- MUL is the low 9 bits of the product.
REQ-017 Single-cycle ops (ADD, SUB, AND, OR, XOR, LDI):
- an op accepted in cycle N loads the WB register (wr_en, wr_addr=in_dst, wr_data=result) at the end of cycle N;
- wr_en is high for exactly cycle N+1.
REQ-018 LDI SHALL write in_imm and ignore both source operands.
REQ-019 NOP SHALL be accepted normally and SHALL produce wr_en=0 in cycle N+1.
REQ-020 A cycle with no transfer SHALL produce wr_en=0 in the following cycle.
REQ-021 The FSM SHALL have two states, RUN and MUL; in_ready=1 in RUN and in_ready=0 in MUL.
REQ-022 RUN -> MUL on acceptance of a MUL op. On that edge:
- the two operands are latched;
- the accumulator is cleared;
- the iteration counter is set to 9;
- the WB register is loaded with wr_en=0.
REQ-023 Each cycle in MUL SHALL perform one shift-add step on the latched multiplicand/multiplier bits and decrement the counter.
REQ-024 MUL -> RUN when the counter reaches 0.
- A MUL accepted in cycle N occupies cycles N+1..N+9 in MUL.
- The WB register loads the product at the end of cycle N+9, so wr_en is high in cycle N+10.
- wr_en=0 in cycles N+2..N+9.
REQ-025 The first instruction after a MUL can be accepted in cycle N+10 and SHALL bypass the MUL result per REQ-015.
REQ-026 Writes to the same register in consecutive instructions SHALL be accepted with no stall; the later write wins.
REQ-027 retire_cnt SHALL increment by 1 on every cycle with wr_en=1 and SHALL wrap from 65535 to 0.
REQ-028 busy SHALL be high in MUL and low in RUN.

Reset
REQ-029 While rst=1 at a clock edge, the block SHALL load:
- FSM=RUN;
- wr_en=0, wr_addr=0, wr_data=0;
- iteration counter=0 and accumulator=0;
- retire_cnt=0.
REQ-030 Outputs after that edge SHALL be in_ready=1 and busy=0.
REQ-031 Reset during MUL SHALL abort the multiply, and no write for it SHALL ever be issued.
REQ-032 An instruction presented on the reset cycle SHALL be discarded.

Verification
REQ-033 A bench SHALL cover the following directed scenarios:
- LDI r1,5; LDI r2,7; ADD r3,r1,r2 back-to-back -> wr_en high on 3 consecutive cycles, and the last write is r3=12 via bypass on r2.
- r1=3, SUB r0,r1,r2 with r2=5 -> wr_data=510.
- r1=25, r2=30, MUL r3,r1,r2 in cycle N -> in_ready=0 and busy=1 in cycles N+1..N+9; wr_en=1 with r3=238 (750 mod 512) in cycle N+10.
- MUL r0 followed by ADD r1,r0,r0 held valid -> ADD accepted in cycle N+10, uses the bypassed product, and writes r1=2*product mod 512 in cycle N+11.
- rst asserted in cycle N+4 of a MUL -> no write is ever issued for it, retire_cnt=0, in_ready=1 the next cycle.
- 4 NOPs then LDI r0,511 -> exactly one write, and retire_cnt increments by exactly 1.

Source files
------------

// File: rtl/alu_wb_stage.sv
// alu_wb_stage
//   Single-issue ALU stage with a registered write-back port and an iterative
//   shift-add multiplier. Single-cycle ops write back one cycle after they are
//   accepted. MUL stalls intake for 9 cycles and then writes back the product.
//   Source operands bypass from the write-back register when its address
//   matches, so back-to-back dependent instructions need no stall.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   in_valid, in_ready            instruction handshake
//   in_op, in_dst, in_src0/1      opcode, destination and source indices
//   in_imm                        immediate used by LDI
//   rd0_addr/rd1_addr             register-file read addresses (= sources)
//   rd0_data/rd1_data             combinational register-file read data
//   wr_en, wr_addr, wr_data       register-file write port (registered)
//   busy                          high while the multiplier is running
//   retire_cnt                    count of issued register writes, wraps
//
// state | meaning
// ------+------------------------------------------------------------
// RUN   | accepting instructions, single-cycle ops complete here
// MUL   | shift-add multiply in progress, intake stalled
module alu_wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [1:0]  in_dst,
  input  logic [1:0]  in_src0,
  input  logic [1:0]  in_src1,
  input  logic [8:0]  in_imm,
  output logic [1:0]  rd0_addr,
  output logic [1:0]  rd1_addr,
  input  logic [8:0]  rd0_data,
  input  logic [8:0]  rd1_data,
  output logic        wr_en,
  output logic [1:0]  wr_addr,
  output logic [8:0]  wr_data,
  output logic        busy,
  output logic [15:0] retire_cnt
);

  localparam logic [0:0] S_RUN = 1'b0;
  localparam logic [0:0] S_MUL = 1'b1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  logic [0:0] state;
  logic [3:0] mul_cnt;
  logic [8:0] mul_acc;
  logic [8:0] mul_cand;
  logic [8:0] mul_plier;
  logic [1:0] mul_dst;

  logic [8:0] op_a;
  logic [8:0] op_b;
  logic [8:0] alu_res;
  logic [8:0] mul_next;
  logic       accept;
  logic       op_writes;

  assign rd0_addr = in_src0;
  assign rd1_addr = in_src1;
  assign in_ready = (state == S_RUN);
  assign busy     = (state == S_MUL);
  assign accept   = in_valid & in_ready;
  assign op_writes = (in_op != OP_NOP) && (in_op != OP_MUL);

  // The write-back register holds the value the register file will see at
  // the end of this cycle, so it is the freshest copy of that register.
  assign op_a = (wr_en && (wr_addr == in_src0)) ? wr_data : rd0_data;
  assign op_b = (wr_en && (wr_addr == in_src1)) ? wr_data : rd1_data;

  // Multiplicand shifts left within 9 bits, so partial products beyond bit 8
  // drop out and the accumulator holds the product modulo 512.
  assign mul_next = mul_acc + (mul_plier[0] ? mul_cand : 9'd0);

  always_comb begin
    alu_res = '0;
    case (in_op)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_LDI:  alu_res = in_imm;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_RUN;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      mul_cnt    <= '0;
      mul_acc    <= '0;
      mul_cand   <= '0;
      mul_plier  <= '0;
      mul_dst    <= '0;
      retire_cnt <= '0;
    end else begin
      if (wr_en) retire_cnt <= retire_cnt + 16'd1;

      case (state)
        S_RUN: begin
          if (accept && (in_op == OP_MUL)) begin
            state     <= S_MUL;
            mul_cand  <= op_a;
            mul_plier <= op_b;
            mul_acc   <= '0;
            mul_cnt   <= 4'd9;
            mul_dst   <= in_dst;
            wr_en     <= 1'b0;
          end else if (accept) begin
            wr_en   <= op_writes;
            wr_addr <= in_dst;
            wr_data <= alu_res;
          end else begin
            wr_en <= 1'b0;
          end
        end
        default: begin
          mul_acc   <= mul_next;
          mul_cand  <= {mul_cand[7:0], 1'b0};
          mul_plier <= {1'b0, mul_plier[8:1]};
          mul_cnt   <= mul_cnt - 4'd1;
          if (mul_cnt == 4'd1) begin
            state   <= S_RUN;
            wr_en   <= 1'b1;
            wr_addr <= mul_dst;
            wr_data <= mul_next;
          end else begin
            wr_en <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
